dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache that sits directly below the CPU's data port. It consumes the CPU's per-cycle data request (address, read enable, byte write enables, store data) and returns load data plus the global `stall`. It talks to main memory through a single valid/ready request channel and a response channel that returns one word per beat. Line fills are 4 words.

## Interface
- `INDEX_BITS`, default 6: number of lines is 2^INDEX_BITS (64 lines × 16 B = 1 KB).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous reset, active-high.
- `cpu_addr` input 32: byte address of the request; held stable by the CPU while `stall`=1.
- `cpu_re` input 1: load request.
- `cpu_we` input 4: byte write enables; nonzero means store.
- `cpu_din` input 32: store data, already byte-lane aligned.
- `cpu_dout` output 32: load data, valid the cycle after the request is accepted.
- `stall` output 1: freezes the CPU pipeline.
- `mem_req_valid` output 1: memory request present.
- `mem_req_ready` input 1: memory accepts the request this cycle.
- `mem_req_rnw` output 1: 1 = line read, 0 = word write.
- `mem_req_addr` output 32: line-aligned address for reads, word-aligned address for writes.
- `mem_req_data` output 32: write data.
- `mem_req_mask` output 4: byte mask for writes; 0 for reads.
- `mem_resp_valid` input 1: one fill beat this cycle.
- `mem_resp_data` input 32: fill beat data, in ascending word order.

## Operation
- **Cacheable request:** `cpu_addr[31:30]`==0 and `cpu_addr[28]`==1, with `cpu_re`=1 or `cpu_we`≠0. Other requests are ignored: no stall, and `cpu_dout`=0 the next cycle.
- **Address fields:**
  - offset = `addr[3:2]`
  - index = `addr[INDEX_BITS+3:4]`
  - tag = `addr[31:INDEX_BITS+4]`
- **Storage:** one valid bit per line (flops, cleared by reset), a tag array, and a data array. Both arrays are synchronous-read.
- **Request capture:** while `stall`=0, every cycle registers the request (addr, re, we, din) into `pend` and issues the array reads. While `stall`=1, `pend` holds its value.
- **Store priority:** if `cpu_re` and `cpu_we` are both set, the request is treated as a store.
- **States:** IDLE, WRITE, FILL_REQ, FILL_DATA, RESP.
- **IDLE with a pending cacheable request:**
  - Load hit: `cpu_dout` = data array word. Stay in IDLE. No stall.
  - Load miss: `stall`=1 combinationally. Go to FILL_REQ.
  - Store: `stall`=1. If it hits, merge the masked bytes into the data array this cycle. Go to WRITE. Misses do not allocate.
- **WRITE:**
  - Drives `mem_req_valid`=1, `rnw`=0, addr = `{pend.addr[31:2],2'b00}`, data = `pend.din`, mask = `pend.we`.
  - On `mem_req_ready`, go to IDLE. `stall` drops in that IDLE cycle, and `pend` may recapture.
- **FILL_REQ:**
  - Drives `mem_req_valid`=1, `rnw`=1, addr = `{pend.addr[31:4],4'b0}`.
  - On `mem_req_ready`, clear the 2-bit beat counter and go to FILL_DATA.
- **FILL_DATA:**
  - Each `mem_resp_valid` writes word[counter] of the line and increments the counter.
  - The beat whose counter equals `pend` offset is captured into a critical-word register.
  - On the 4th beat: set the line's tag and valid bit, then go to RESP.
- **RESP:**
  - `stall`=0 and `cpu_dout` = critical-word register.
  - `pend` captures the next request. Next state is IDLE.
  - A request captured in RESP is looked up normally in the following IDLE cycle.
- **`stall` summary:** 1 in WRITE, FILL_REQ and FILL_DATA, and in IDLE when the pending request is a store or a load miss. 0 otherwise.
- **Reset:**
  - All valid bits clear; state goes to IDLE; `pend` is cleared to no-request.
  - Outputs: `stall`=0, `cpu_dout`=0, `mem_req_valid`=0, `rnw`=0, `addr`/`data`/`mask` = 0.
  - Reset during a fill abandons the fill, and any later response beats are ignored. The memory side is reset by the same `rst`.
- **Response ordering:** `mem_resp_valid` outside FILL_DATA is ignored.

## Timing
- The request is registered at edge N.
- **Load hit:** `cpu_dout` is valid in cycle N+1 with zero stall cycles.
- **Load miss:**
  - `stall` is high from N+1.
  - FILL_REQ is in N+2.
  - With `ready` in N+2 and beats in N+3..N+6, RESP is in N+7.
  - That gives 6 stall cycles, plus one extra for each cycle `ready` is withheld or beats are delayed.
- **Store:**
  - `stall` is high in N+1.
  - WRITE is in N+2.
  - With `ready` in N+2, `stall` drops at N+3, giving 2 stall cycles minimum.
- **Handshake:** `mem_req_*` stay constant while `valid`=1 and `ready`=0. `valid` never drops without `ready`.
- **Store then load to the same word:** the store's array update precedes the load's lookup, so the load returns the merged data.

## Test plan
- **Cold read:** `rst`, then load 0x1000_0004; memory beats 0xA0, 0xA1, 0xA2, 0xA3 with `ready` immediate.
  - `stall` high for exactly 6 cycles; `mem_req_addr`=0x1000_0000; `cpu_dout`=0xA1 in RESP.
  - A following load of 0x1000_000C returns 0xA3 with no stall.
- **Store hit, byte merge:** after the fill above, store `cpu_we`=4'b0010, `din`=0x0000_5500 to 0x1000_0004.
  - One write request: `mask`=0010, `data`=0x0000_5500.
  - A reload of 0x1000_0004 returns 0x0000_55A1 with no stall.
- **Store miss, no allocate:** store to 0x1000_0400 (same index, different tag).
  - Write request only.
  - A reload of 0x1000_0004 still hits and returns 0x0000_55A1.
- **Backpressure:** load miss with `mem_req_ready` low for 3 cycles, then `ready` high and beats spaced 2 cycles apart.
  - `mem_req_*` stable while waiting; `stall` covers the whole interval.
  - The correct critical word is returned, and no spurious `mem_resp` is consumed.
- **Uncached and reset mid-fill:**
  - Load 0x8000_0000: no stall, no memory request, `cpu_dout`=0.
  - Assert `rst` after the 2nd fill beat: `stall`=0 immediately, state IDLE, the line invalid, and the next load of that line misses.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Four-word lines, one valid/ready request channel and a per-beat response channel to memory.
module dcache_ctrl #(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_re,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_rnw,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_mask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int unsigned Lines   = 2 ** INDEX_BITS;
  localparam int unsigned TagBits = 32 - INDEX_BITS - 4;

  typedef enum logic [2:0] {StIdle, StWrite, StFillReq, StFillData, StResp} state_e;

  state_e                  state_q;
  logic [1:0]              beat_q;
  logic [31:0]             crit_q;
  logic [31:2]             pend_addr_q;
  logic                    pend_re_q;
  logic [3:0]              pend_we_q;
  logic [31:0]             pend_din_q;
  logic [Lines-1:0]        valid_q;
  logic [TagBits-1:0]      tag_mem [Lines];
  logic [31:0]             data_mem [Lines*4];
  logic [TagBits-1:0]      tag_rd_q;
  logic [31:0]             data_rd_q;

  logic [INDEX_BITS-1:0]   cpu_idx;
  logic [INDEX_BITS-1:0]   pend_idx;
  logic [1:0]              pend_off;
  logic [TagBits-1:0]      pend_tag;
  logic                    pend_cacheable;
  logic                    pend_store;
  logic                    pend_hit;
  logic                    idle_active;
  logic                    fill_last;
  logic                    data_we;
  logic [INDEX_BITS+1:0]   data_waddr;
  logic [31:0]             data_wdata;
  logic                    unused_addr_lsb;

  // Byte offset within a word is irrelevant: all accesses are whole words plus byte enables.
  assign unused_addr_lsb = ^cpu_addr[1:0];

  assign cpu_idx        = cpu_addr[INDEX_BITS+3:4];
  assign pend_idx       = pend_addr_q[INDEX_BITS+3:4];
  assign pend_off       = pend_addr_q[3:2];
  assign pend_tag       = pend_addr_q[31:INDEX_BITS+4];
  assign pend_cacheable = (pend_addr_q[31:30] == 2'b00) && pend_addr_q[28] &&
                          (pend_re_q || (pend_we_q != 4'b0000));
  assign pend_store     = (pend_we_q != 4'b0000);
  assign pend_hit       = valid_q[pend_idx] && (tag_rd_q == pend_tag);
  assign idle_active    = (state_q == StIdle) && pend_cacheable;
  assign fill_last      = (state_q == StFillData) && mem_resp_valid && (beat_q == 2'd3);

  // Stall: memory-bound states, or an IDLE lookup that needs memory (store or load miss).
  always_comb begin
    stall = 1'b0;
    case (state_q)
      StIdle:                         stall = idle_active && (pend_store || !pend_hit);
      StWrite, StFillReq, StFillData: stall = 1'b1;
      default:                        stall = 1'b0;
    endcase
  end

  // Load data: critical word in RESP, array word on an IDLE load hit, zero otherwise.
  always_comb begin
    cpu_dout = '0;
    if (state_q == StResp) begin
      cpu_dout = crit_q;
    end else if (idle_active && !pend_store && pend_hit) begin
      cpu_dout = data_rd_q;
    end
  end

  // Memory request channel, derived purely from state and the held pending request.
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_rnw   = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    mem_req_mask  = '0;
    if (state_q == StWrite) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = {pend_addr_q[31:2], 2'b00};
      mem_req_data  = pend_din_q;
      mem_req_mask  = pend_we_q;
    end else if (state_q == StFillReq) begin
      mem_req_valid = 1'b1;
      mem_req_rnw   = 1'b1;
      mem_req_addr  = {pend_addr_q[31:4], 4'b0000};
    end
  end

  // Single data-array write port: store-hit byte merge in IDLE, or a fill beat.
  always_comb begin
    data_we    = 1'b0;
    data_waddr = {pend_idx, pend_off};
    data_wdata = '0;
    if (idle_active && pend_store && pend_hit) begin
      data_we = 1'b1;
      for (int b = 0; b < 4; b++) begin
        data_wdata[8*b +: 8] = pend_we_q[b] ? pend_din_q[8*b +: 8] : data_rd_q[8*b +: 8];
      end
    end else if ((state_q == StFillData) && mem_resp_valid) begin
      data_we    = 1'b1;
      data_waddr = {pend_idx, beat_q};
      data_wdata = mem_resp_data;
    end
  end

  // Tag/data arrays: synchronous read of the incoming request whenever the pipe advances.
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[data_waddr] <= data_wdata;
    end
    if (fill_last) begin
      tag_mem[pend_idx] <= pend_tag;
    end
    if (!stall) begin
      data_rd_q <= data_mem[{cpu_idx, cpu_addr[3:2]}];
      tag_rd_q  <= tag_mem[cpu_idx];
    end
  end

  // Valid bits: cleared by reset, set when a line fill completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_last) begin
      valid_q[pend_idx] <= 1'b1;
    end
  end

  // Pending request: captured while not stalled; a completed write retires it so IDLE is free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_addr_q <= '0;
      pend_re_q   <= 1'b0;
      pend_we_q   <= '0;
      pend_din_q  <= '0;
    end else if ((state_q == StWrite) && mem_req_ready) begin
      pend_re_q <= 1'b0;
      pend_we_q <= '0;
    end else if (!stall) begin
      pend_addr_q <= cpu_addr[31:2];
      pend_re_q   <= cpu_re;
      pend_we_q   <= cpu_we;
      pend_din_q  <= cpu_din;
    end
  end

  // Controller FSM with fill beat counter and critical-word capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      beat_q  <= '0;
      crit_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (idle_active) begin
            if (pend_store) begin
              state_q <= StWrite;
            end else if (!pend_hit) begin
              state_q <= StFillReq;
            end
          end
        end
        StWrite: begin
          if (mem_req_ready) state_q <= StIdle;
        end
        StFillReq: begin
          if (mem_req_ready) begin
            beat_q  <= '0;
            state_q <= StFillData;
          end
        end
        StFillData: begin
          if (mem_resp_valid) begin
            if (beat_q == pend_off) crit_q <= mem_resp_data;
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) state_q <= StResp;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: cold fill, store merge, store miss, backpressure, reset mid-fill.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr;
  logic        cpu_re;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_rnw;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dcache_ctrl #(.INDEX_BITS(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_addr       (cpu_addr),
    .cpu_re         (cpu_re),
    .cpu_we         (cpu_we),
    .cpu_din        (cpu_din),
    .cpu_dout       (cpu_dout),
    .stall          (stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_rnw    (mem_req_rnw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_mask   (mem_req_mask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
  endtask

  task automatic cpu_idle();
    cpu_re = 1'b0;
    cpu_we = 4'b0000;
  endtask

  // Present a load at this negedge; next negedge must show a zero-stall hit.
  task automatic load_hit(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    cpu_addr = addr; cpu_re = 1'b1; cpu_we = 4'b0000; cpu_din = '0;
    @(negedge clk);
    check({tag, " stall"}, 32'(stall), 32'd0);
    check({tag, " dout"}, cpu_dout, exp);
    cpu_idle();
  endtask

  // Load miss with memory model: ready after ready_wait cycles, beats every gap cycles,
  // optional junk response beats while no fill is in progress. Returns at the RESP negedge.
  task automatic load_miss(input string tag, input logic [31:0] addr, input logic [31:0] base,
                           input int ready_wait, input int gap, input bit junk,
                           input int exp_stalls);
    int stalls   = 0;
    int wait_cnt = 0;
    int gap_cnt  = 0;
    int beat     = 0;
    bit granted  = 1'b0;
    bit done     = 1'b0;
    logic [31:0] exp_dout;
    exp_dout = base + 32'(addr[3:2]);
    cpu_addr = addr; cpu_re = 1'b1; cpu_we = 4'b0000; cpu_din = '0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      if (!stall) begin
        done = 1'b1;
        check({tag, " crit word"}, cpu_dout, exp_dout);
        check({tag, " stall cycles"}, 32'(stalls), 32'(exp_stalls));
        cpu_idle();
      end else begin
        stalls++;
        if (granted && beat < 4) begin
          if (gap_cnt == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = base + 32'(beat);
            beat++;
            gap_cnt = gap - 1;
          end else begin
            gap_cnt--;
          end
        end
        if (mem_req_valid) begin
          check({tag, " req rnw"}, 32'(mem_req_rnw), 32'd1);
          check({tag, " req addr"}, mem_req_addr, {addr[31:4], 4'h0});
          check({tag, " req mask"}, 32'(mem_req_mask), 32'd0);
          if (wait_cnt == ready_wait) begin
            mem_req_ready = 1'b1;
            granted = 1'b1;
          end else begin
            wait_cnt++;
          end
        end
        if (junk && !granted) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = 32'hDEAD_BEEF;
        end
      end
    end
    check({tag, " completed"}, 32'(done), 32'd1);
  endtask

  // Store with immediate ready: expect exactly one write request and 2 stall cycles.
  task automatic store(input string tag, input logic [31:0] addr, input logic [3:0] we,
                       input logic [31:0] din);
    int stalls = 0;
    int writes = 0;
    int reads  = 0;
    bit done   = 1'b0;
    cpu_addr = addr; cpu_re = 1'b0; cpu_we = we; cpu_din = din;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      if (!stall) begin
        done = 1'b1;
        cpu_idle();
      end else begin
        stalls++;
        if (mem_req_valid) begin
          if (mem_req_rnw) reads++;
          check({tag, " wr addr"}, mem_req_addr, {addr[31:2], 2'b00});
          check({tag, " wr data"}, mem_req_data, din);
          check({tag, " wr mask"}, 32'(mem_req_mask), 32'(we));
          mem_req_ready = 1'b1;
          writes++;
        end
      end
    end
    check({tag, " completed"}, 32'(done), 32'd1);
    check({tag, " stall cycles"}, 32'(stalls), 32'd2);
    check({tag, " write reqs"}, 32'(writes), 32'd1);
    check({tag, " read reqs"}, 32'(reads), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    cpu_addr = '0; cpu_re = 1'b0; cpu_we = '0; cpu_din = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    repeat (2) @(negedge clk);
    check("reset stall", 32'(stall), 32'd0);
    check("reset dout", cpu_dout, 32'd0);
    check("reset req valid", 32'(mem_req_valid), 32'd0);
    check("reset req addr", mem_req_addr, 32'd0);
    check("reset req mask", 32'(mem_req_mask), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Cold read, then hit on another word of the same line.
    load_miss("cold", 32'h1000_0004, 32'h0000_00A0, 0, 1, 1'b0, 6);
    load_hit("hit word3", 32'h1000_000C, 32'h0000_00A3);

    // Store hit with byte merge, then reload sees merged word.
    store("st hit", 32'h1000_0004, 4'b0010, 32'h0000_5500);
    load_hit("reload merged", 32'h1000_0004, 32'h0000_55A1);

    // Store miss to same index, different tag: write only, line untouched.
    store("st miss", 32'h1000_0400, 4'b1111, 32'hFFFF_FFFF);
    load_hit("reload after miss", 32'h1000_0004, 32'h0000_55A1);

    // Backpressure: ready withheld 3 cycles, beats 2 cycles apart, junk beats beforehand.
    load_miss("bp", 32'h1000_0028, 32'h0000_00B0, 3, 2, 1'b1, 12);
    load_hit("bp word3", 32'h1000_002C, 32'h0000_00B3);
    load_hit("bp word0", 32'h1000_0020, 32'h0000_00B0);

    // Uncached load: no stall, no memory request, zero data.
    cpu_addr = 32'h8000_0000; cpu_re = 1'b1; cpu_we = '0;
    @(negedge clk);
    check("uncached stall", 32'(stall), 32'd0);
    check("uncached req", 32'(mem_req_valid), 32'd0);
    check("uncached dout", cpu_dout, 32'd0);
    cpu_idle();
    @(negedge clk);
    check("uncached req later", 32'(mem_req_valid), 32'd0);

    // Reset after the 2nd fill beat.
    cpu_addr = 32'h1000_0010; cpu_re = 1'b1; cpu_we = '0;
    @(negedge clk);
    check("midfill miss stall", 32'(stall), 32'd1);
    @(negedge clk);
    check("midfill fill req", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_00C0;
    @(negedge clk);
    mem_resp_data = 32'h0000_00C1;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    cpu_idle();
    rst = 1'b1;
    #1;
    check("rst stall", 32'(stall), 32'd0);
    check("rst req valid", 32'(mem_req_valid), 32'd0);
    check("rst dout", cpu_dout, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_00C2;
    @(negedge clk);
    mem_resp_data = 32'h0000_00C3;
    check("stray beat stall", 32'(stall), 32'd0);
    check("stray beat req", 32'(mem_req_valid), 32'd0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("after stray stall", 32'(stall), 32'd0);

    // Abandoned line and previously valid line must both miss now.
    load_miss("refill", 32'h1000_0010, 32'h0000_00D0, 0, 1, 1'b0, 6);
    load_miss("post-rst line0", 32'h1000_0004, 32'h0000_00E0, 0, 1, 1'b0, 6);
    load_hit("post-rst hit", 32'h1000_0008, 32'h0000_00E2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
